cache_l2_arbiter: RTL and testbench

Responder-side arbiter between the split L1 caches and the unified L2. Accepts 128-bit line requests from the I-cache (read-only) and D-cache (read/write), serialises them onto the single L2 port, and returns the L2 response to the granted requester. Sits between the L1 miss/writeback logic and the L2 cache in the memory hierarchy.

---
 rtl/cache_l2_arbiter.sv | 139 +++++++++++++
 tb/tb_cache_l2_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_l2_arbiter.sv
// cache_l2_arbiter
//   Arbitrates the split L1 I-cache and D-cache onto the single unified L2
//   port. One request is granted at a time. Its address, operation and write
//   line are latched when it is granted, and the L2 completion is steered back
//   to the requester that was granted. After every completion there is a
//   one-cycle RELEASE gap with all outputs low. This gives the requester time
//   to drop its request, so a request that was just serviced is not granted a
//   second time.
//
// Parameters
//   FIXED_DPRIO    1: D-cache wins simultaneous requests; 0: round-robin on ties
//
// Ports
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   i_mem_read     I-cache line read request (held until i_mem_resp)
//   i_mem_address  I-cache line address
//   i_mem_rdata    line returned to I-cache (wired to l2_rdata)
//   i_mem_resp     one-cycle completion pulse to I-cache
//   d_mem_read     D-cache line read request (held until d_mem_resp)
//   d_mem_write    D-cache writeback request (held until d_mem_resp)
//   d_mem_address  D-cache line address
//   d_mem_wdata    D-cache writeback line
//   d_mem_rdata    line returned to D-cache (wired to l2_rdata)
//   d_mem_resp     one-cycle completion pulse to D-cache
//   l2_read        L2 read strobe, held until l2_resp
//   l2_write       L2 write strobe, held until l2_resp
//   l2_address     L2 line address (latched)
//   l2_wdata       L2 write line (latched)
//   l2_rdata       L2 read line, valid with l2_resp
//   l2_resp        one-cycle L2 completion pulse
module cache_l2_arbiter #(
  parameter logic FIXED_DPRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_mem_read,
  input  logic [15:0]  i_mem_address,
  output logic [127:0] i_mem_rdata,
  output logic         i_mem_resp,
  input  logic         d_mem_read,
  input  logic         d_mem_write,
  input  logic [15:0]  d_mem_address,
  input  logic [127:0] d_mem_wdata,
  output logic [127:0] d_mem_rdata,
  output logic         d_mem_resp,
  output logic         l2_read,
  output logic         l2_write,
  output logic [15:0]  l2_address,
  output logic [127:0] l2_wdata,
  input  logic [127:0] l2_rdata,
  input  logic         l2_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t         state_q, state_d;
  logic           last_d_q, last_d_d;    // 1: last grant went to D, 0: to I
  logic           wr_q, wr_d;
  logic [15:0]    addr_q, addr_d;
  logic [127:0]   wdata_q, wdata_d;

  logic           i_req, d_req, grant_d, grant_i;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;
  // D wins when it is the only requester, when D has fixed priority, or when
  // there is a tie and I was granted last.
  assign grant_d = d_req & (~i_req | FIXED_DPRIO | ~last_d_q);
  assign grant_i = i_req & ~grant_d;

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    i_mem_resp = 1'b0;
    d_mem_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
          addr_d   = d_mem_address;
          wr_d     = d_mem_write;   // read+write together counts as a write
          wdata_d  = d_mem_wdata;
        end else if (grant_i) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
          addr_d   = i_mem_address;
          wr_d     = 1'b0;
        end
      end
      SERVE_I: begin
        l2_read  = ~wr_q;
        l2_write = wr_q;
        if (l2_resp) begin
          i_mem_resp = 1'b1;
          state_d    = RELEASE;
        end
      end
      SERVE_D: begin
        l2_read  = ~wr_q;
        l2_write = wr_q;
        if (l2_resp) begin
          d_mem_resp = 1'b1;
          state_d    = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign l2_address  = addr_q;
  assign l2_wdata    = wdata_q;
  assign i_mem_rdata = l2_rdata;
  assign d_mem_rdata = l2_rdata;

endmodule

// File: tb/tb_cache_l2_arbiter.sv
module tb_cache_l2_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_mem_read, d_mem_read, d_mem_write, l2_resp;
  logic [15:0]  i_mem_address, d_mem_address;
  logic [127:0] d_mem_wdata, l2_rdata;

  logic [127:0] i_mem_rdata0, d_mem_rdata0, l2_wdata0;
  logic [127:0] i_mem_rdata1, d_mem_rdata1, l2_wdata1;
  logic         i_mem_resp0, d_mem_resp0, l2_read0, l2_write0;
  logic         i_mem_resp1, d_mem_resp1, l2_read1, l2_write1;
  logic [15:0]  l2_address0, l2_address1;

  always #5 clk = ~clk;

  cache_l2_arbiter #(.FIXED_DPRIO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_rdata(i_mem_rdata0), .i_mem_resp(i_mem_resp0),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata0), .d_mem_resp(d_mem_resp0),
    .l2_read(l2_read0), .l2_write(l2_write0), .l2_address(l2_address0),
    .l2_wdata(l2_wdata0), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  cache_l2_arbiter #(.FIXED_DPRIO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_rdata(i_mem_rdata1), .i_mem_resp(i_mem_resp1),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata1), .d_mem_resp(d_mem_resp1),
    .l2_read(l2_read1), .l2_write(l2_write1), .l2_address(l2_address1),
    .l2_wdata(l2_wdata1), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  // Expected transaction on the round-robin instance, plus which side the
  // fixed-priority instance is expected to answer for the same L2 pulse.
  typedef struct {
    logic         is_d;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic         d1_is_d;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [127:0] mdl_wdata;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic wr, input logic [15:0] addr,
                      input logic [127:0] wdata, input logic d1_is_d);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = addr; e.wdata = wdata; e.d1_is_d = d1_is_d;
    sb.push_back(e);
  endtask

  // Wait for the next grant, compare it with the scoreboard head, answer after
  // 'delay' strobe cycles, then check the RELEASE and IDLE cycles (l2_resp is
  // deliberately kept high through both to show it is ignored there).
  task automatic serve_txn(input int delay, input logic [127:0] rd, input bit drop);
    exp_t e;
    bit seen;
    logic [15:0]  sa_i, sa_d;
    logic [127:0] sw;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (l2_read0 | l2_write0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("grant_seen", seen, 1);
    chk("sb_nonempty", sb.size() != 0, 1);
    if (!seen || sb.size() == 0) return;
    e = sb.pop_front();
    // Requester inputs are scrambled during service; the L2 side must not move.
    sa_i = i_mem_address; sa_d = d_mem_address; sw = d_mem_wdata;
    i_mem_address = ~sa_i; d_mem_address = ~sa_d; d_mem_wdata = ~sw;
    for (int c = 1; c <= delay; c++) begin
      if (c > 1) cyc();
      if (c == delay) begin
        l2_resp  = 1'b1;
        l2_rdata = rd;
      end
      #1;
      chk("l2_read", l2_read0, !e.wr);
      chk("l2_write", l2_write0, e.wr);
      chk("l2_address", l2_address0, e.addr);
      chk("l2_wdata", l2_wdata0, e.wdata);
    end
    chk("i_mem_resp", i_mem_resp0, !e.is_d);
    chk("d_mem_resp", d_mem_resp0, e.is_d);
    chk("i_mem_rdata", i_mem_rdata0, rd);
    chk("d_mem_rdata", d_mem_rdata0, rd);
    chk("fix_i_resp", i_mem_resp1, !e.d1_is_d);
    chk("fix_d_resp", d_mem_resp1, e.d1_is_d);
    cyc();
    i_mem_address = sa_i; d_mem_address = sa_d; d_mem_wdata = sw;
    if (drop) begin
      i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
    end
    #1;
    chk("rel_strobes", {l2_read0, l2_write0, l2_read1, l2_write1}, 0);
    chk("rel_resps", {i_mem_resp0, d_mem_resp0, i_mem_resp1, d_mem_resp1}, 0);
    cyc();
    chk("idle_strobes", {l2_read0, l2_write0, l2_read1, l2_write1}, 0);
    chk("idle_resps", {i_mem_resp0, d_mem_resp0, i_mem_resp1, d_mem_resp1}, 0);
    l2_resp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] wd;
    bit seen;
    rst_n = 1'b0;
    i_mem_read = 1'b1; i_mem_address = 16'h1230;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = 16'h0; d_mem_wdata = '0;
    l2_resp = 1'b0; l2_rdata = '0;
    mdl_wdata = '0;

    // Reset held two cycles with an I request present.
    cyc(); cyc();
    chk("rst_strobes", {l2_read0, l2_write0, l2_read1, l2_write1}, 0);
    chk("rst_resps", {i_mem_resp0, d_mem_resp0, i_mem_resp1, d_mem_resp1}, 0);
    chk("rst_addr", l2_address0, 0);
    chk("rst_wdata", l2_wdata0, 0);

    // I read released from reset; strobe on the next cycle.
    rst_n = 1'b1;
    push(1'b0, 1'b0, 16'h1230, mdl_wdata, 1'b0);
    serve_txn(4, 128'hDEADBEEF_00000000_00000000_00000001, 1'b1);

    // D writeback.
    d_mem_write = 1'b1; d_mem_address = 16'h8040; d_mem_wdata = {16{8'hA5}};
    mdl_wdata = {16{8'hA5}};
    push(1'b1, 1'b1, 16'h8040, mdl_wdata, 1'b1);
    serve_txn(3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1);

    // D read and write both high count as a write; I read afterwards keeps the
    // previously latched write line.
    d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_address = 16'h0ABC;
    d_mem_wdata = 128'h11112222_33334444_55556666_77778888;
    mdl_wdata = d_mem_wdata;
    push(1'b1, 1'b1, 16'h0ABC, mdl_wdata, 1'b1);
    serve_txn(2, 128'h5, 1'b1);
    i_mem_read = 1'b1; i_mem_address = 16'h7777;
    push(1'b0, 1'b0, 16'h7777, mdl_wdata, 1'b0);
    serve_txn(1, 128'h6, 1'b1);

    // Ties from reset with both sides held: round-robin D,I,D,I; fixed D always.
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    mdl_wdata = '0;
    wd = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D;
    i_mem_read = 1'b1; i_mem_address = 16'h2000;
    d_mem_read = 1'b1; d_mem_address = 16'h3000; d_mem_wdata = wd;
    push(1'b1, 1'b0, 16'h3000, wd, 1'b1);
    push(1'b0, 1'b0, 16'h2000, wd, 1'b1);
    push(1'b1, 1'b0, 16'h3000, wd, 1'b1);
    push(1'b0, 1'b0, 16'h2000, wd, 1'b1);
    serve_txn(1, 128'hA1, 1'b0);
    serve_txn(2, 128'hA2, 1'b0);
    serve_txn(3, 128'hA3, 1'b0);
    serve_txn(1, 128'hA4, 1'b1);

    // Reset in the middle of a D writeback.
    d_mem_write = 1'b1; d_mem_address = 16'h4444; d_mem_wdata = {8{16'hBEEF}};
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (l2_write0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mid_grant", seen, 1);
    chk("mid_addr", l2_address0, 16'h4444);
    rst_n = 1'b0;
    d_mem_write = 1'b0;
    cyc();
    chk("mid_rst_strobes", {l2_read0, l2_write0, l2_read1, l2_write1}, 0);
    chk("mid_rst_addr", l2_address0, 0);
    rst_n = 1'b1;
    l2_resp = 1'b1; l2_rdata = 128'hFF;
    #1;
    chk("late_resp", {i_mem_resp0, d_mem_resp0, i_mem_resp1, d_mem_resp1}, 0);
    cyc();
    chk("late_resp2", {i_mem_resp0, d_mem_resp0, i_mem_resp1, d_mem_resp1}, 0);
    chk("late_strobes", {l2_read0, l2_write0, l2_read1, l2_write1}, 0);
    l2_resp = 1'b0;
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
